rs_station: RTL

- Reservation station for one functional unit class; the receiving end of the common data bus.
- Accepts issued instructions whose operands are either values or 5-bit producer labels.
- Snoops every CDB broadcast (enable, label, data) and captures matching operands.
- Dispatches operand-complete entries to its functional unit with a valid/ready handshake. The entry's own label later returns on the CDB with the result.

---
 rtl/rs_station.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rs_station.sv
// Reservation station: holds issued instructions, captures operands off the CDB,
// and presents the lowest-index operand-complete entry to its functional unit.
`timescale 1ns/1ps
module rs_station #(
  parameter int DEPTH      = 3,
  parameter int BASE_LABEL = 1,
  parameter int OP_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [OP_W-1:0] issue_op,
  input  logic [31:0]     issue_vj,
  input  logic [4:0]      issue_qj,
  input  logic [31:0]     issue_vk,
  input  logic [4:0]      issue_qk,
  output logic [4:0]      issue_label,
  input  logic            cdb_en,
  input  logic [4:0]      cdb_label,
  input  logic [31:0]     cdb_data,
  output logic            disp_valid,
  input  logic            disp_ready,
  output logic [OP_W-1:0] disp_op,
  output logic [31:0]     disp_a,
  output logic [31:0]     disp_b,
  output logic [4:0]      disp_label,
  output logic [3:0]      busy_count
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]  op_q [DEPTH];
  logic [OP_W-1:0]  op_d [DEPTH];
  logic [31:0]      vj_q [DEPTH];
  logic [31:0]      vj_d [DEPTH];
  logic [31:0]      vk_q [DEPTH];
  logic [31:0]      vk_d [DEPTH];
  logic [4:0]       qj_q [DEPTH];
  logic [4:0]       qj_d [DEPTH];
  logic [4:0]       qk_q [DEPTH];
  logic [4:0]       qk_d [DEPTH];
  logic [3:0]       cnt_q, cnt_d;

  logic [DEPTH-1:0] free_oh, rdy_oh;
  logic             issue_fire, disp_fire;

  // One-hot picks of the lowest free entry and the lowest ready entry,
  // both from registered state only.
  always_comb begin : pick
    logic found_f, found_r;
    free_oh = '0;
    rdy_oh  = '0;
    found_f = 1'b0;
    found_r = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !found_f) begin
        free_oh[i] = 1'b1;
        found_f    = 1'b1;
      end
      if (busy_q[i] && qj_q[i] == 5'd0 && qk_q[i] == 5'd0 && !found_r) begin
        rdy_oh[i] = 1'b1;
        found_r   = 1'b1;
      end
    end
  end

  always_comb begin
    issue_ready = |free_oh;
    issue_label = 5'd0;
    disp_valid  = |rdy_oh;
    disp_op     = '0;
    disp_a      = 32'd0;
    disp_b      = 32'd0;
    disp_label  = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_oh[i]) issue_label = 5'(BASE_LABEL + i);
      if (rdy_oh[i]) begin
        disp_op    = op_q[i];
        disp_a     = vj_q[i];
        disp_b     = vk_q[i];
        disp_label = 5'(BASE_LABEL + i);
      end
    end
  end

  assign issue_fire = issue_valid & issue_ready;
  assign disp_fire  = disp_valid & disp_ready;
  assign busy_count = cnt_q;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    qj_d   = qj_q;
    vk_d   = vk_q;
    qk_d   = qk_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        op_d[i] = '0;
        vj_d[i] = 32'd0;
        qj_d[i] = 5'd0;
        vk_d[i] = 32'd0;
        qk_d[i] = 5'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_en && cdb_label != 5'd0 && busy_q[i]) begin
          if (qj_q[i] == cdb_label) begin
            vj_d[i] = cdb_data;
            qj_d[i] = 5'd0;
          end
          if (qk_q[i] == cdb_label) begin
            vk_d[i] = cdb_data;
            qk_d[i] = 5'd0;
          end
        end
        if (disp_fire && rdy_oh[i]) busy_d[i] = 1'b0;
        // A label broadcast in the issue cycle is taken directly, never waited on.
        if (issue_fire && free_oh[i]) begin
          busy_d[i] = 1'b1;
          op_d[i]   = issue_op;
          if (cdb_en && issue_qj != 5'd0 && cdb_label == issue_qj) begin
            vj_d[i] = cdb_data;
            qj_d[i] = 5'd0;
          end else begin
            vj_d[i] = issue_vj;
            qj_d[i] = issue_qj;
          end
          if (cdb_en && issue_qk != 5'd0 && cdb_label == issue_qk) begin
            vk_d[i] = cdb_data;
            qk_d[i] = 5'd0;
          end else begin
            vk_d[i] = issue_vk;
            qk_d[i] = issue_qk;
          end
        end
      end
      cnt_d = cnt_q + 4'(issue_fire) - 4'(disp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= 32'd0;
        qj_q[i] <= 5'd0;
        vk_q[i] <= 32'd0;
        qk_q[i] <= 5'd0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      qj_q   <= qj_d;
      vk_q   <= vk_d;
      qk_q   <= qk_d;
    end
  end

endmodule
